// File: rtl/lms_sequencer.sv
// Control sequencer for the LMS adaptive FIR: per sample, a delay-line write, NTAPS MAC
// reads, an error latch, then (optionally) NTAPS coefficient read-modify-write cycles.
module lms_sequencer #(
    parameter int NTAPS = 31,
    parameter int AW    = 5
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          ready_in,
    input  logic          adapt_en_in,
    output logic          sample_we_out,
    output logic [AW-1:0] sample_waddr_out,
    output logic [AW-1:0] sample_raddr_out,
    output logic [AW-1:0] coeff_raddr_out,
    output logic [AW-1:0] coeff_waddr_out,
    output logic          coeff_we_out,
    output logic          mac_clear_out,
    output logic          mac_en_out,
    output logic          y_valid_out,
    output logic          err_latch_out,
    output logic          done_out,
    output logic          busy_out,
    output logic          overrun_out
);

    // MAC_TAIL and UPD_TAIL cover the extra cycle needed by the 1-cycle RAM read latency.
    typedef enum logic [2:0] {IDLE, WRITE, FILTER, MAC_TAIL, EST, UPDATE, UPD_TAIL} state_t;

    localparam logic [AW-1:0] KLAST = AW'(NTAPS - 1);

    state_t        state, state_nx;
    logic [AW-1:0] k, k_nx, k_inc;
    logic [AW-1:0] offset, offset_nx;
    logic          adapt, adapt_nx;

    logic          sample_we_nx, coeff_we_nx, mac_clear_nx, mac_en_nx;
    logic          y_valid_nx, err_latch_nx, done_nx, busy_nx, overrun_nx;
    logic [AW-1:0] sample_waddr_nx, sample_raddr_nx, coeff_raddr_nx, coeff_waddr_nx;

    always_comb begin
        state_nx        = state;
        k_nx            = k;
        k_inc           = k + 1'b1;
        offset_nx       = offset;
        adapt_nx        = adapt;
        sample_we_nx    = 1'b0;
        coeff_we_nx     = 1'b0;
        mac_clear_nx    = 1'b0;
        mac_en_nx       = 1'b0;
        y_valid_nx      = 1'b0;
        err_latch_nx    = 1'b0;
        done_nx         = 1'b0;
        sample_waddr_nx = sample_waddr_out;
        sample_raddr_nx = sample_raddr_out;
        coeff_raddr_nx  = coeff_raddr_out;
        coeff_waddr_nx  = coeff_waddr_out;
        overrun_nx      = overrun_out | (ready_in & busy_out);

        case (state)
            IDLE: begin
                if (ready_in) begin
                    state_nx        = WRITE;
                    adapt_nx        = adapt_en_in;
                    sample_we_nx    = 1'b1;
                    sample_waddr_nx = offset;
                    mac_clear_nx    = 1'b1;
                end
            end
            WRITE: begin
                state_nx        = FILTER;
                k_nx            = '0;
                sample_raddr_nx = offset;
                coeff_raddr_nx  = '0;
            end
            FILTER: begin
                mac_en_nx = 1'b1;
                if (k == KLAST) begin
                    state_nx = MAC_TAIL;
                end else begin
                    k_nx            = k_inc;
                    sample_raddr_nx = offset - k_inc;
                    coeff_raddr_nx  = k_inc;
                end
            end
            MAC_TAIL: begin
                state_nx     = EST;
                y_valid_nx   = 1'b1;
                err_latch_nx = 1'b1;
                done_nx      = ~adapt;
            end
            EST: begin
                if (adapt) begin
                    state_nx        = UPDATE;
                    k_nx            = '0;
                    sample_raddr_nx = offset;
                    coeff_raddr_nx  = '0;
                end else begin
                    state_nx  = IDLE;
                    offset_nx = offset + 1'b1;
                end
            end
            UPDATE: begin
                coeff_we_nx    = 1'b1;
                coeff_waddr_nx = k;
                if (k == KLAST) begin
                    state_nx = UPD_TAIL;
                    done_nx  = 1'b1;
                end else begin
                    k_nx            = k_inc;
                    sample_raddr_nx = offset - k_inc;
                    coeff_raddr_nx  = k_inc;
                end
            end
            UPD_TAIL: begin
                state_nx  = IDLE;
                offset_nx = offset + 1'b1;
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= IDLE;
            k                <= '0;
            offset           <= '0;
            adapt            <= 1'b0;
            sample_we_out    <= 1'b0;
            sample_waddr_out <= '0;
            sample_raddr_out <= '0;
            coeff_raddr_out  <= '0;
            coeff_waddr_out  <= '0;
            coeff_we_out     <= 1'b0;
            mac_clear_out    <= 1'b0;
            mac_en_out       <= 1'b0;
            y_valid_out      <= 1'b0;
            err_latch_out    <= 1'b0;
            done_out         <= 1'b0;
            busy_out         <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            state            <= state_nx;
            k                <= k_nx;
            offset           <= offset_nx;
            adapt            <= adapt_nx;
            sample_we_out    <= sample_we_nx;
            sample_waddr_out <= sample_waddr_nx;
            sample_raddr_out <= sample_raddr_nx;
            coeff_raddr_out  <= coeff_raddr_nx;
            coeff_waddr_out  <= coeff_waddr_nx;
            coeff_we_out     <= coeff_we_nx;
            mac_clear_out    <= mac_clear_nx;
            mac_en_out       <= mac_en_nx;
            y_valid_out      <= y_valid_nx;
            err_latch_out    <= err_latch_nx;
            done_out         <= done_nx;
            busy_out         <= busy_nx;
            overrun_out      <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_lms_sequencer.sv
// Bench for lms_sequencer: a timeline model (cycle offsets from the accepted strobe)
// predicts every output each cycle; random adapt, gaps, extra strobes and resets.
module tb_lms_sequencer;

    localparam int N  = 31;
    localparam int AW = 5;

    logic clk = 1'b0, rst = 1'b1, ready = 1'b0, adapt_en = 1'b0;
    logic sample_we, coeff_we, mac_clear, mac_en, y_valid, err_latch, done, busy, overrun;
    logic [AW-1:0] sample_waddr, sample_raddr, coeff_raddr, coeff_waddr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lms_sequencer #(.NTAPS(N), .AW(AW)) dut (
        .clk_in(clk), .rst_in(rst), .ready_in(ready), .adapt_en_in(adapt_en),
        .sample_we_out(sample_we), .sample_waddr_out(sample_waddr),
        .sample_raddr_out(sample_raddr), .coeff_raddr_out(coeff_raddr),
        .coeff_waddr_out(coeff_waddr), .coeff_we_out(coeff_we),
        .mac_clear_out(mac_clear), .mac_en_out(mac_en), .y_valid_out(y_valid),
        .err_latch_out(err_latch), .done_out(done), .busy_out(busy), .overrun_out(overrun)
    );

    // Reference: rel = cycles since the accepted strobe T; windows taken from the timeline.
    bit            m_act = 0, m_ad = 0, m_ov = 0;
    int            rel = 0;
    logic [AW-1:0] m_off = '0, m_off_s = '0;
    logic [AW-1:0] e_swaddr = '0, e_sraddr = '0, e_craddr = '0, e_cwaddr = '0;

    function automatic int last_rel(bit a);
        return a ? 4 + 2 * N : 3 + N;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0; rel = 0; m_off = '0; m_ov = 0;
            e_swaddr = '0; e_sraddr = '0; e_craddr = '0; e_cwaddr = '0;
        end else begin
            if (m_act) begin
                if (ready) m_ov = 1;
                if (rel == last_rel(m_ad)) begin
                    m_act = 0;
                    m_off = m_off + 1'b1;
                end else begin
                    rel++;
                end
            end else if (ready) begin
                m_act = 1; rel = 1; m_off_s = m_off; m_ad = adapt_en;
            end
            if (m_act) begin
                if (rel == 1) e_swaddr = m_off_s;
                if (rel >= 2 && rel <= 1 + N) begin
                    e_sraddr = m_off_s - AW'(rel - 2);
                    e_craddr = AW'(rel - 2);
                end
                if (m_ad && rel >= 4 + N && rel <= 3 + 2 * N) begin
                    e_sraddr = m_off_s - AW'(rel - 4 - N);
                    e_craddr = AW'(rel - 4 - N);
                end
                if (m_ad && rel >= 5 + N) e_cwaddr = AW'(rel - 5 - N);
            end
        end
    end

    wire e_swe   = m_act && rel == 1;
    wire e_clr   = m_act && rel == 1;
    wire e_mac   = m_act && rel >= 3 && rel <= 2 + N;
    wire e_yv    = m_act && rel == 3 + N;
    wire e_cwe   = m_act && m_ad && rel >= 5 + N && rel <= 4 + 2 * N;
    wire e_done  = m_act && rel == last_rel(m_ad);

    wire [29:0] dut_vec = {sample_we, sample_waddr, sample_raddr, coeff_raddr, coeff_waddr,
                           coeff_we, mac_clear, mac_en, y_valid, err_latch, done, busy, overrun};
    wire [29:0] exp_vec = {e_swe, e_swaddr, e_sraddr, e_craddr, e_cwaddr,
                           e_cwe, e_clr, e_mac, e_yv, e_yv, e_done, m_act, m_ov};

    task automatic test_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checks++;
        if (dut_vec !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", dut_vec, 30'h0);
        end
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL reset_idle c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_adapt_sample(input bit a, input string name);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk); checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL %s c=%0d got=%h exp=%h", name, c, dut_vec, exp_vec);
            end
            ready = (c == 0);
            adapt_en = (c == 0) ? a : 1'($urandom);
        end
    endtask

    task automatic test_overrun();
        int extra = $urandom_range(1, 60);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk); checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL overrun c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            ready = (c == 0 || c == 10 || c == extra);
            adapt_en = (c == 0) ? 1'b1 : 1'($urandom);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky got=%b exp=1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        int stop = 20 + $urandom_range(0, 30);
        for (int c = 0; c < stop; c++) begin
            @(negedge clk); checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL mid_pre c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            ready = (c == 0);
            adapt_en = 1'b1;
        end
        @(negedge clk);
        ready = 1'b0;
        #3 rst = 1'b1;
        #1 checks++;
        if (dut_vec !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", dut_vec, 30'h0);
        end
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 4 * 128; c++) begin
            @(negedge clk); checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL spaced c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (c % 128 == 0 && sample_we !== 1'b0) begin
                failures++;
                $display("FAIL spaced_we_window c=%0d got=%b exp=0", c, sample_we);
            end
            if (c % 128 == 1) begin
                checks++;
                if (sample_waddr !== AW'(c / 128)) begin
                    failures++;
                    $display("FAIL spaced_waddr c=%0d got=%0d exp=%0d", c, sample_waddr, c / 128);
                end
            end
            ready = (c % 128 == 0);
            adapt_en = 1'($urandom);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL spaced_overrun got=%b exp=0", overrun);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            ready = ($urandom_range(0, 39) == 0);
            adapt_en = 1'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_adapt_sample(1'b1, "adapt_first");
        test_adapt_sample(1'($urandom), "wrap_second");
        test_adapt_sample(1'b0, "no_adapt");
        test_overrun();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
